// File: rtl/jtframe_pkg.sv
// Shared types and constants for the ROM client: FSM states, SDRAM address width
// and the WAIT-state timeout limit.
package jtframe_pkg;

  localparam int unsigned SDRAM_AW      = 22;
  localparam int unsigned TIMEOUT_LIMIT = 255;

  typedef logic [SDRAM_AW-1:0] sdram_addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/jtframe_rom_client.sv
// Single-line (32-bit) ROM cache between a game and the SDRAM controller.
// Optional JTFRAME_ROMRQ_TIMEOUT_EN: re-issue the request after TIMEOUT_LIMIT idle WAIT cycles.
module jtframe_rom_client
  import jtframe_pkg::*;
#(
  parameter int unsigned AW     = 17,
  parameter sdram_addr_t OFFSET = 22'h0
) (
  input  logic                clk_rom,
  input  logic                rst_n,
  input  logic                loop_rst,
  input  logic                downloading,
  input  logic                cs,
  input  logic [AW-1:0]       addr,
  output logic [15:0]         dout,
  output logic                data_ok,
  output logic                sdram_req,
  input  logic                sdram_ack,
  output logic [SDRAM_AW-1:0] sdram_addr,
  input  logic [31:0]         data_read,
  input  logic                data_rdy
);

  localparam int unsigned TW = AW - 1;

  state_e          state_q, state_d;
  logic            valid_q, valid_d;
  logic [TW-1:0]   tag_q, tag_d;
  logic [TW-1:0]   pend_q, pend_d;
  logic [31:0]     line_q, line_d;
  sdram_addr_t     addr_q, addr_d;
  logic            req_q, req_d;
  logic            inval;
  logic            hit;
  logic            capture;
`ifdef JTFRAME_ROMRQ_TIMEOUT_EN
  logic [7:0]      cnt_q, cnt_d;
  logic            timeout;
`endif

  assign inval   = loop_rst | downloading;
  assign hit     = cs & valid_q & (tag_q == addr[AW-1:1]) & (state_q == IDLE);
  // Data is taken in WAIT, or in REQ when ack and data arrive together
  assign capture = data_rdy & ((state_q == WAIT) | ((state_q == REQ) & sdram_ack));
`ifdef JTFRAME_ROMRQ_TIMEOUT_EN
  assign timeout = (state_q == WAIT) & (cnt_q == 8'(TIMEOUT_LIMIT - 1));
`endif

  // Hit path is combinational so the game sees data with zero latency
  assign data_ok    = hit;
  assign dout       = addr[0] ? line_q[31:16] : line_q[15:0];
  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;

  // State register
  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      tag_q   <= '0;
      pend_q  <= '0;
      line_q  <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
`ifdef JTFRAME_ROMRQ_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      pend_q  <= pend_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
`ifdef JTFRAME_ROMRQ_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (inval) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (cs && !hit) state_d = REQ;
        REQ:  if (sdram_ack) state_d = data_rdy ? IDLE : WAIT;
        WAIT: begin
          if (data_rdy) state_d = IDLE;
`ifdef JTFRAME_ROMRQ_TIMEOUT_EN
          else if (timeout) state_d = REQ;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath / registered outputs
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    pend_d  = pend_q;
    line_d  = line_q;
    addr_d  = addr_q;
    req_d   = (state_d == REQ);
`ifdef JTFRAME_ROMRQ_TIMEOUT_EN
    cnt_d   = ((state_q == WAIT) && (state_d == WAIT)) ? cnt_q + 8'd1 : 8'd0;
`endif
    if (inval) begin
      valid_d = 1'b0;
    end else begin
      if ((state_q == IDLE) && (state_d == REQ)) begin
        pend_d = addr[AW-1:1];
        addr_d = OFFSET + sdram_addr_t'({addr[AW-1:1], 1'b0});
      end
      if (capture) begin
        line_d  = data_read;
        tag_d   = pend_q;
        valid_d = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jtframe_rom_client.sv
// Scoreboard bench for jtframe_rom_client: randomized reads against a line-cache
// model, an SDRAM responder, and directed fetch/invalidate/timeout scenarios.
module tb_jtframe_rom_client;

  localparam logic [21:0] OFF  = 22'h0;
  localparam logic [21:0] WOFF = 22'h3FFFFE;

  logic        clk_rom = 1'b0;
  logic        rst_n = 1'b0, loop_rst = 1'b0, downloading = 1'b0, cs = 1'b0;
  logic        sdram_ack = 1'b0, data_rdy = 1'b0, w_ack = 1'b0;
  logic [16:0] addr = '0;
  logic [31:0] data_read = '0;
  logic [15:0] dout, w_dout;
  logic        data_ok, w_ok, sdram_req, w_req;
  logic [21:0] sdram_addr, w_addr;

  int vectors = 0, miscompares = 0;
  int cyc = 0, rdy_cyc = 0;
  int issued_n = 0, done_n = 0, ack_n = 0, rdy_n = 0;
  int rdy_min = 0;
  bit resp_busy = 1'b0, hold = 1'b0;

  bit          m_valid = 1'b0;
  logic [15:0] m_tag = '0;
  logic [31:0] m_line = '0;
  bit          ovr_en = 1'b0;
  logic [21:0] ovr_addr = '0;
  logic [31:0] ovr_data = '0;

  logic [15:0] exp_q[$];
  bit          miss_q[$];
  logic [21:0] req_exp_q[$];

  jtframe_rom_client #(.AW(17), .OFFSET(OFF)) u_dut (
    .clk_rom(clk_rom), .rst_n(rst_n), .loop_rst(loop_rst), .downloading(downloading),
    .cs(cs), .addr(addr), .dout(dout), .data_ok(data_ok),
    .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_addr(sdram_addr),
    .data_read(data_read), .data_rdy(data_rdy)
  );

  // Never acknowledged: only its wrapped request address is observed
  jtframe_rom_client #(.AW(17), .OFFSET(WOFF)) u_wrap (
    .clk_rom(clk_rom), .rst_n(rst_n), .loop_rst(loop_rst), .downloading(downloading),
    .cs(cs), .addr(addr), .dout(w_dout), .data_ok(w_ok),
    .sdram_req(w_req), .sdram_ack(w_ack), .sdram_addr(w_addr),
    .data_read(data_read), .data_rdy(data_rdy)
  );

  initial forever #5 clk_rom = ~clk_rom;
  initial forever begin @(posedge clk_rom); cyc++; end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [21:0] a);
    if (ovr_en && a == ovr_addr) return ovr_data;
    return {a[15:0] ^ 16'h9E37, a[15:0] + 16'h4C1D};
  endfunction

  function automatic logic [21:0] word_addr(input logic [16:0] a);
    return OFF + 22'({a[16:1], 1'b0});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  task automatic tick();
    @(posedge clk_rom);
    #1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && issued_n != done_n; i++) @(negedge clk_rom);
    if (issued_n != done_n) begin
      check("data_ok_timeout", 32'(done_n), 32'(issued_n));
      finish_run();
    end
  endtask

  // SDRAM responder: acks after a random delay, then returns the line
  logic [21:0] taken;
  int          dly;
  bit          same;
  initial begin
    forever begin
      @(negedge clk_rom);
      if (rst_n && sdram_req) begin
        resp_busy = 1'b1;
        taken = sdram_addr;
        if (req_exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_req: actual=%h required=none", sdram_addr);
        end else begin
          check("sdram_addr", 32'(sdram_addr), 32'(req_exp_q.pop_front()));
        end
        dly = $urandom_range(0, 2);
        repeat (dly) @(negedge clk_rom);
        same = (rdy_min == 0) && !hold && ($urandom_range(0, 3) == 0);
        sdram_ack = 1'b1;
        ack_n++;
        if (same) begin
          data_read = mem_word(taken);
          data_rdy  = 1'b1;
          rdy_cyc   = cyc;
          rdy_n++;
        end
        @(negedge clk_rom);
        sdram_ack = 1'b0;
        if (same) begin
          data_rdy = 1'b0;
        end else begin
          repeat (rdy_min + int'($urandom_range(0, 3))) @(negedge clk_rom);
          for (int i = 0; i < 2000 && hold; i++) @(negedge clk_rom);
          data_read = mem_word(taken);
          data_rdy  = 1'b1;
          rdy_cyc   = cyc;
          rdy_n++;
          @(negedge clk_rom);
          data_rdy = 1'b0;
        end
        resp_busy = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents data for an open request
  logic [15:0] mon_e;
  bit          mon_m;
  initial begin
    forever begin
      @(negedge clk_rom);
      if (rst_n && sdram_req) check("ok_in_req", 32'(data_ok), 32'(0));
      if (rst_n && cs && data_ok && issued_n != done_n) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_data: actual=%h required=none", dout);
        end else begin
          mon_e = exp_q.pop_front();
          mon_m = miss_q.pop_front();
          check("dout", 32'(dout), 32'(mon_e));
          if (mon_m) check("ok_latency", 32'(cyc), 32'(rdy_cyc + 1));
        end
        done_n++;
      end
    end
  end

  task automatic issue(input logic [16:0] a);
    logic [21:0] sa;
    logic [31:0] w;
    bit          miss;
    sa   = word_addr(a);
    w    = mem_word(sa);
    miss = !(m_valid && m_tag == a[16:1]);
    exp_q.push_back(a[0] ? w[31:16] : w[15:0]);
    miss_q.push_back(miss);
    if (miss) req_exp_q.push_back(sa);
    tick();
    addr = a;
    cs   = 1'b1;
    issued_n++;
    @(negedge clk_rom);
    if (miss) begin
      check("miss_ok_low", 32'(data_ok), 32'(0));
      @(negedge clk_rom);
      check("req_latency", 32'(sdram_req), 32'(1));
    end else begin
      check("hit_ok", 32'(data_ok), 32'(1));
      check("hit_noreq", 32'(sdram_req), 32'(0));
    end
    wait_done();
    m_valid = 1'b1;
    m_tag   = a[16:1];
    m_line  = w;
    tick();
    cs = 1'b0;
  endtask

  task automatic flush_line();
    tick();
    cs = 1'b0;
    downloading = 1'b1;
    tick();
    downloading = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic wait_ack(input int k);
    for (int i = 0; i < 100 && ack_n == k; i++) tick();
    check("ack_seen", 32'(ack_n != k), 32'(1));
  endtask

  int          k, r, seen;
  logic [31:0] saved;
  logic [21:0] first_a;
  logic [16:0] ra;

  initial begin
    // Reset state
    repeat (2) @(negedge clk_rom);
    check("rst_dout", 32'(dout), 32'(0));
    check("rst_ok", 32'(data_ok), 32'(0));
    check("rst_req", 32'(sdram_req), 32'(0));
    check("rst_addr", 32'(sdram_addr), 32'(0));
    tick();
    rst_n = 1'b1;

    // Cold miss, then hit on the other half of the line
    ovr_en = 1'b1; ovr_addr = 22'h4; ovr_data = 32'hBEEF_CAFE;
    issue(17'h00004);
    check("wrap_req", 32'(w_req), 32'(1));
    check("wrap_addr", 32'(w_addr), 32'(22'h000002));
    issue(17'h00005);

    // Address change while waiting for data
    flush_line();
    rdy_min = 3;
    req_exp_q.push_back(word_addr(17'h10));
    req_exp_q.push_back(word_addr(17'h40));
    exp_q.push_back(mem_word(word_addr(17'h40)) & 32'hFFFF);
    miss_q.push_back(1'b1);
    k = ack_n; r = rdy_n;
    tick();
    addr = 17'h10; cs = 1'b1; issued_n++;
    wait_ack(k);
    addr = 17'h40;
    for (int i = 0; i < 100 && rdy_n == r; i++) tick();
    saved = mem_word(word_addr(17'h10));
    check("mid_line_stored", 32'(dout), 32'(saved[15:0]));
    check("mid_ok_low", 32'(data_ok), 32'(0));
    tick();
    check("mid_req_again", 32'(sdram_req), 32'(1));
    check("mid_req_addr", 32'(sdram_addr), 32'(word_addr(17'h40)));
    wait_done();
    rdy_min = 0;
    m_valid = 1'b1; m_tag = 16'h20; m_line = mem_word(word_addr(17'h40));
    tick();
    cs = 1'b0;

    // Invalidation during WAIT; the late data must be dropped
    issue(17'h60);
    saved = m_line;
    rdy_min = 4;
    req_exp_q.push_back(word_addr(17'h80));
    k = ack_n;
    tick();
    addr = 17'h80; cs = 1'b1;
    wait_ack(k);
    cs = 1'b0; loop_rst = 1'b1;
    tick();
    loop_rst = 1'b0;
    for (int i = 0; i < 100 && resp_busy; i++) @(negedge clk_rom);
    rdy_min = 0;
    tick();
    check("inval_line_kept", 32'(dout), 32'(saved[15:0]));
    check("inval_ok_low", 32'(data_ok), 32'(0));
    m_valid = 1'b0;
    issue(17'h60);

    // Withheld data: re-issue only when the timeout feature is built in
    flush_line();
    hold = 1'b1;
    exp_q.push_back(mem_word(word_addr(17'hA0)) & 32'hFFFF);
    miss_q.push_back(1'b1);
    req_exp_q.push_back(word_addr(17'hA0));
`ifdef JTFRAME_ROMRQ_TIMEOUT_EN
    req_exp_q.push_back(word_addr(17'hA0));
`endif
    k = ack_n;
    tick();
    addr = 17'hA0; cs = 1'b1; issued_n++;
    wait_ack(k);
    seen = 0; first_a = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_rom);
      if (sdram_req && seen == 0) first_a = sdram_addr;
      if (sdram_req) seen++;
    end
`ifdef JTFRAME_ROMRQ_TIMEOUT_EN
    check("timeout_reissue", 32'(seen != 0), 32'(1));
    check("timeout_addr", 32'(first_a), 32'(word_addr(17'hA0)));
`else
    check("no_timeout_req", 32'(seen), 32'(0));
`endif
    hold = 1'b0;
    wait_done();
    m_valid = 1'b1; m_tag = 16'h50; m_line = mem_word(word_addr(17'hA0));
    tick();
    cs = 1'b0;

    // Randomized traffic with occasional download pulses
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        flush_line();
      end else begin
        ra = ($urandom_range(0, 7) == 0) ? 17'($urandom) : 17'($urandom_range(0, 23));
        issue(ra);
      end
    end

    // Asynchronous reset mid-cycle clears the line and request address
    @(posedge clk_rom);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_dout", 32'(dout), 32'(0));
    check("async_rst_addr", 32'(sdram_addr), 32'(0));
    check("async_rst_ok", 32'(data_ok), 32'(0));

    finish_run();
  end

endmodule

// File: doc/jtframe_rom_client.md
JTFRAME_ROM_CLIENT -- requirements
Module: jtframe_rom_client

Interface
REQ-001 Parameter AW, default 17: game-side address width, in 16-bit word units.
REQ-002 Parameter OFFSET, default 22'h0: word offset added to every SDRAM address.
REQ-003 Clock and reset are decided as follows: one clock, clk_rom; reset is asynchronous and active-low, rst_n.
REQ-004 Port clk_rom, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port loop_rst, input, 1: SDRAM controller init in progress; invalidates the line and holds IDLE.
REQ-007 Port downloading, input, 1: ROM download active; same effect as loop_rst.
REQ-008 Port cs, input, 1: game requests data at addr.
REQ-009 Port addr, input, AW: game 16-bit word address.
REQ-010 Port dout, output, 16: requested word.
REQ-011 Port data_ok, output, 1: dout is valid for the current addr.
REQ-012 Port sdram_req, output, 1: request to the SDRAM controller.
REQ-013 Port sdram_ack, input, 1: controller accepted the request.
REQ-014 Port sdram_addr, output, 22: SDRAM word address.
REQ-015 Port data_read, input, 32: fetched 32-bit line.
REQ-016 Port data_rdy, input, 1: data_read is valid this cycle.

Function
REQ-017 Cache: one 32-bit line, tag = addr[AW-1:1], valid bit.
REQ-018 Hit = cs & valid & (tag == addr[AW-1:1]) & (state == IDLE).
REQ-019 On a hit, data_ok is asserted in the same cycle (combinational, zero latency).
REQ-020 dout = line[15:0] when addr[0]=0, line[31:16] when addr[0]=1 (little-endian).
REQ-021 State machine states are IDLE, REQ and WAIT.
REQ-022 IDLE->REQ: a miss (cs=1, no hit, loop_rst=0, downloading=0); addr[AW-1:1] is latched as the pending tag.
REQ-023 In REQ: sdram_req=1 and sdram_addr = OFFSET + {pending_tag,1'b0}, zero-extended to 22 bits with wrap modulo 2^22.
REQ-024 In REQ: sdram_req is held until sdram_ack, then the block moves to WAIT.
REQ-025 sdram_req is never asserted outside REQ.
REQ-026 In WAIT: on data_rdy, line <= data_read, tag <= pending tag, valid <= 1, and the block returns to IDLE.
REQ-027 sdram_ack and data_rdy in the same cycle: the data is captured and the block returns directly to IDLE.
REQ-028 Miss latency: sdram_req rises 1 cycle after the missing cs/addr; data_ok rises the cycle after data_rdy.
REQ-029 A change of addr or cs during REQ/WAIT does not abort the fetch.
REQ-030 After a fetch completes, a still-pending miss for the new addr starts from IDLE on the next cycle.
REQ-031 data_ok = 0 whenever state is not IDLE.
REQ-032 loop_rst or downloading high in any state: valid <= 0, state <= IDLE, sdram_req <= 0 next cycle; a late data_rdy is ignored.

Reset
REQ-033 rst_n=0 asynchronously clears the following: state=IDLE, valid=0, tag=0, line=0, sdram_req=0, sdram_addr=0, data_ok=0, dout=0.

Configuration
REQ-034 Macro JTFRAME_ROMRQ_TIMEOUT_EN defined: an 8-bit counter runs in WAIT; at 255 cycles without data_rdy, the block returns to REQ and re-issues the same sdram_addr.
REQ-035 Macro JTFRAME_ROMRQ_TIMEOUT_EN undefined: no counter exists, and WAIT persists until data_rdy or invalidation.

Structure
REQ-036 Package jtframe_pkg holds the state enum (IDLE/REQ/WAIT), the SDRAM address width constant (22) and the timeout limit constant (255).
REQ-037 No sub-module is used; the design is a single flat module.

Verification
REQ-038 Cold miss: cs=1, addr=17'h00004, ack after 2 cycles, data_rdy with 32'hBEEF_CAFE after 4 cycles -> sdram_addr=22'h4, dout=16'hCAFE, data_ok the cycle after data_rdy.
REQ-039 Hit: after the REQ-038 fetch, set addr=17'h00005 -> dout=16'hBEEF, data_ok=1 the same cycle, sdram_req stays 0.
REQ-040 Offset wrap: OFFSET=22'h3FFFFE, addr=17'h00004 -> sdram_addr=22'h000002.
REQ-041 Address change mid-fetch: addr changes from 0x10 to 0x40 during WAIT -> the line for 0x10 is stored, then a new sdram_req with sdram_addr=OFFSET+0x40 one cycle after IDLE.
REQ-042 Invalidation: assert loop_rst during WAIT, then data_rdy arrives -> line unchanged, valid=0; the next cs to the same addr misses.
REQ-043 Timeout (macro defined): withhold data_rdy for 255 cycles -> sdram_req reasserted with the same address; without the macro, sdram_req stays 0.
